// File: rtl/mips_pkg.sv
// Shared decode definitions: opcodes, functs, ALU/write-back encodings, decoded bundle.
// Used by mips_decode_comb and decoder_control_pipe.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic        reg_dst;
    logic        jump;
    logic        branch;
    logic        branch_ne;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        select_shamt;
    logic [1:0]  mem_to_reg;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] jump_address;
    logic        illegal;
  } bundle_t;

endpackage

// File: rtl/mips_decode_comb.sv
// Purely combinational instruction word to control bundle decode.
// DECODER_ILLEGAL_TRAP_EN: unsupported encodings flag illegal instead of decoding to a NOP.
module mips_decode_comb
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output bundle_t     bundle
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       supported;
  bundle_t    dec;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    dec              = '0;
    supported        = 1'b1;
    dec.rs           = instr[25:21];
    dec.rt           = instr[20:16];
    dec.rd           = instr[15:11];
    dec.shamt        = instr[10:6];
    dec.jump_address = instr[25:0];
    dec.imm          = {{16{instr[15]}}, instr[15:0]};

    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD: dec.alu_ctrl = ALU_ADD;
          FN_SUB: dec.alu_ctrl = ALU_SUB;
          FN_AND: dec.alu_ctrl = ALU_AND;
          FN_OR:  dec.alu_ctrl = ALU_OR;
          FN_SLT: dec.alu_ctrl = ALU_SLT;
          FN_SLL: begin
            dec.alu_ctrl     = ALU_SLL;
            dec.select_shamt = 1'b1;
          end
          FN_SRL: begin
            dec.alu_ctrl     = ALU_SRL;
            dec.select_shamt = 1'b1;
          end
          default: supported = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_SLTI: begin
        dec.alu_ctrl  = ALU_SLT;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_ctrl  = ALU_AND;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = {16'h0000, instr[15:0]};
      end
      OP_ORI: begin
        dec.alu_ctrl  = ALU_OR;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = {16'h0000, instr[15:0]};
      end
      OP_LW: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = WB_MEM;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_BNE: begin
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
        dec.alu_ctrl  = ALU_SUB;
      end
      OP_J: dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = WB_PC4;
        dec.rd         = LINK_REG;
      end
      default: supported = 1'b0;
    endcase
  end

  // Unsupported encodings never carry enables; the trap build only adds the flag.
  always_comb begin
    bundle = dec;
    if (!supported) begin
      bundle = '0;
`ifdef DECODER_ILLEGAL_TRAP_EN
      bundle.illegal = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/decoder_control_pipe.sv
// Decoder front end with a DEPTH-entry in-order queue of control bundles and valid/ready on both sides.
// DECODER_ILLEGAL_TRAP_EN (see mips_decode_comb) selects trapping of unsupported encodings.
module decoder_control_pipe
  import mips_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int DEPTH      = 2,
  parameter  int ALU_CTRL_W = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  RegDst,
  output logic                  Jump,
  output logic                  Branch,
  output logic                  BranchNE,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  ALUSrc,
  output logic                  RegWrite,
  output logic                  select_shamt,
  output logic [1:0]            MemtoReg,
  output logic [ALU_CTRL_W-1:0] ALU_Control,
  output logic [XLEN-1:0]       imm_extended,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [4:0]            shamt,
  output logic [25:0]           jump_address,
  output logic                  illegal,
  output logic                  decoder_done,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  bundle_t          dec;
  bundle_t          mem [DEPTH];
  bundle_t          head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  mips_decode_comb u_decode (
    .instr  (instr[31:0]),
    .bundle (dec)
  );

  assign in_ready  = (cnt < CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Flushed entries are discarded silently, so no done pulse either.
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      done <= pop;
    end
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign RegDst       = head.reg_dst;
  assign Jump         = head.jump;
  assign Branch       = head.branch;
  assign BranchNE     = head.branch_ne;
  assign MemRead      = head.mem_read;
  assign MemWrite     = head.mem_write;
  assign ALUSrc       = head.alu_src;
  assign RegWrite     = head.reg_write;
  assign select_shamt = head.select_shamt;
  assign MemtoReg     = head.mem_to_reg;
  assign ALU_Control  = ALU_CTRL_W'(head.alu_ctrl);
  assign imm_extended = XLEN'(head.imm);
  assign rs           = head.rs;
  assign rt           = head.rt;
  assign rd           = head.rd;
  assign shamt        = head.shamt;
  assign jump_address = head.jump_address;
  assign illegal      = head.illegal;
  assign decoder_done = done;
  assign count        = cnt;

endmodule
